// File: rtl/ripple_counter_pkg.sv
// Shared constants and types for the ripple-style up-counter.
package ripple_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef logic [3:0] count4_t;

endpackage

// File: rtl/t_ff_stage.sv
// Single toggle flip-flop stage with synchronous active-high reset and registered complement.
module t_ff_stage (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q,
    output logic q_bar
);

    logic r_q;
    logic r_q_bar;

    // The complement is held in its own flop so q_bar is registered, not derived from q.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q     <= 1'b0;
            r_q_bar <= 1'b1;
        end else if (t) begin
            r_q     <= ~r_q;
            r_q_bar <= ~r_q_bar;
        end
    end

    assign q     = r_q;
    assign q_bar = r_q_bar;

endmodule

// File: rtl/ripple_up_counter_4bit.sv
// Synchronous up-counter built from a chain of T flip-flop stages.
// Optional terminal-count output tc is enabled by defining RIPPLE_UP_COUNTER_TC_EN.
module ripple_up_counter_4bit
    import ripple_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             t,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar
`ifdef RIPPLE_UP_COUNTER_TC_EN
    ,
    output logic             tc
`endif
);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_q_bar;
    logic [WIDTH-1:0] w_stage_t;

    // Stage i toggles when t is high and all lower stages are ones (stage i-1 wraps).
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        if (i == 0) begin : g_lsb
            assign w_stage_t[i] = t;
        end else begin : g_upper
            assign w_stage_t[i] = w_stage_t[i-1] & w_q[i-1];
        end

        t_ff_stage u_stage (
            .clk   (clk),
            .rst   (rst),
            .t     (w_stage_t[i]),
            .q     (w_q[i]),
            .q_bar (w_q_bar[i])
        );
    end

    assign q     = w_q;
    assign q_bar = w_q_bar;

`ifdef RIPPLE_UP_COUNTER_TC_EN
    assign tc = t & (&w_q);
`endif

endmodule

// File: tb/tb_ripple_up_counter_4bit.sv
// Self-checking bench for ripple_up_counter_4bit against an arithmetic reference count.
module tb_ripple_up_counter_4bit;
    import ripple_counter_pkg::*;

    logic       clk;
    logic       rst;
    logic       t;
    logic [3:0] q;
    logic [3:0] q_bar;
`ifdef RIPPLE_UP_COUNTER_TC_EN
    logic       tc;
`endif

    int      checks;
    int      errors;
    count4_t q_ref;
    bit      ref_valid;

    ripple_up_counter_4bit #(
        .WIDTH (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .t     (t),
        .q     (q),
        .q_bar (q_bar)
`ifdef RIPPLE_UP_COUNTER_TC_EN
        ,
        .tc    (tc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock edge: drive inputs, check tc combinationally, clock, check q/q_bar.
    task automatic step(input logic r, input logic tv);
        rst = r;
        t   = tv;
        #1;
`ifdef RIPPLE_UP_COUNTER_TC_EN
        if (ref_valid) begin
            checks++;
            assert (tc === (tv && q_ref == 4'd15)) else begin
                errors++;
                $error("FAIL tc observed=%b expected=%b", tc, (tv && q_ref == 4'd15));
            end
        end
`endif
        @(posedge clk);
        if (r) begin
            q_ref     = '0;
            ref_valid = 1'b1;
        end else begin
            q_ref = (q_ref + (tv ? 4'd1 : 4'd0)) % 16;
        end
        #1;
        if (ref_valid) begin
            check4("q", q, q_ref);
            check4("q_bar", q_bar, ~q_ref);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        ref_valid = 1'b0;
        q_ref     = '0;
        rst       = 1'b1;
        t         = 1'b1;
        @(posedge clk);
        #1;

        // Reset with t high: no counting.
        step(1'b1, 1'b1);
        check4("reset_q", q, 4'd0);
        check4("reset_q_bar", q_bar, 4'hf);
        step(1'b1, 1'b1);
        check4("reset_hold", q, 4'd0);

        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
        check4("count10", q, 4'd10);
        check4("count10_bar", q_bar, 4'b0101);

        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        check4("hold", q, 4'd10);

        for (int i = 0; i < 15; i++) step(1'b0, 1'b1);
        check4("wrap25", q, 4'd9);

        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
        check4("at14_bar", q_bar, 4'b0001);
        step(1'b0, 1'b1);
        check4("at15_bar", q_bar, 4'b0000);
        step(1'b0, 1'b0);
        check4("hold15", q, 4'd15);
        step(1'b0, 1'b1);
        check4("wrap0", q, 4'd0);
        check4("wrap0_bar", q_bar, 4'b1111);

        for (int i = 0; i < 7; i++) step(1'b0, 1'b1);
        check4("at7", q, 4'd7);
        step(1'b1, 1'b1);
        check4("midreset", q, 4'd0);
        step(1'b0, 1'b1);
        check4("resume", q, 4'd1);

        // Random level-enable and occasional reset traffic.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
